// File: rtl/regfile_debug_port_if.sv
// Host/CPU-facing bundle of the register-file debug port.
//   master : the debug initiator (drives halt_req, rf_* selects/write, dump words)
//   slave  : the environment (host link, CPU halt logic, register file)
// Signals:
//   cmd_valid/cmd_op/cmd_ready  host command handshake (op 0 = dump, 1 = load)
//   halt_req/halt_ack           CPU freeze request / acknowledge
//   ld_valid/ld_data/ld_ready   host load-word stream
//   dm_valid/dm_data/dm_idx/dm_ready  dump-word stream
//   rf_we/rf_dr/rf_buss         register-file write port
//   rf_sr1/rf_sr2, rf_ra/rf_rb  register-file read selects and data
//   done/err                    completion pulse and error status
interface regfile_debug_port_if;
  logic        cmd_valid;
  logic        cmd_op;
  logic        cmd_ready;
  logic        halt_req;
  logic        halt_ack;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_ready;
  logic        dm_valid;
  logic [15:0] dm_data;
  logic [2:0]  dm_idx;
  logic        dm_ready;
  logic        rf_we;
  logic [2:0]  rf_dr;
  logic [15:0] rf_buss;
  logic [2:0]  rf_sr1;
  logic [2:0]  rf_sr2;
  logic [15:0] rf_ra;
  logic [15:0] rf_rb;
  logic        done;
  logic        err;

  modport master (
    input  cmd_valid, cmd_op, halt_ack, ld_valid, ld_data, dm_ready, rf_ra, rf_rb,
    output cmd_ready, halt_req, ld_ready, dm_valid, dm_data, dm_idx,
           rf_we, rf_dr, rf_buss, rf_sr1, rf_sr2, done, err
  );

  modport slave (
    output cmd_valid, cmd_op, halt_ack, ld_valid, ld_data, dm_ready, rf_ra, rf_rb,
    input  cmd_ready, halt_req, ld_ready, dm_valid, dm_data, dm_idx,
           rf_we, rf_dr, rf_buss, rf_sr1, rf_sr2, done, err
  );
endinterface

// File: rtl/regfile_debug_port.sv
// Debug initiator for the LC-3 8 x 16-bit register file.
// On a host command it requests a CPU halt, then either dumps all eight
// registers (two per read cycle through SR1/SR2) or loads all eight through
// the write port, always in register order 0..7.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low
//   bus    regfile_debug_port_if.master (command, halt, load, dump and
//          register-file signals)
module regfile_debug_port #(
  parameter int HALT_TIMEOUT = 16
) (
  input logic                   clk,
  input logic                   reset,
  regfile_debug_port_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE, REQ, DUMP_RD, DUMP_OUT0, DUMP_OUT1, LOAD_WAIT, LOAD_WR, DONE
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(HALT_TIMEOUT - 1);

  state_t      state;
  logic        op;
  logic        err_q;
  logic [1:0]  k;      // dump pair counter
  logic [2:0]  i;      // load register index
  logic [7:0]  tcnt;   // halt-request wait counter
  logic [15:0] buf0;
  logic [15:0] buf1;
  logic [15:0] wbuf;
  logic        active;

  // States in which this block owns the register-file ports.
  assign active = (state == DUMP_RD) || (state == DUMP_OUT0) || (state == DUMP_OUT1) ||
                  (state == LOAD_WAIT) || (state == LOAD_WR);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      op    <= 1'b0;
      err_q <= 1'b0;
      k     <= 2'd0;
      i     <= 3'd0;
      tcnt  <= 8'd0;
      buf0  <= 16'd0;
      buf1  <= 16'd0;
      wbuf  <= 16'd0;
    end else if (active && !bus.halt_ack) begin
      // The CPU took its ports back: abandon the transfer, never resume it.
      err_q <= 1'b1;
      state <= DONE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            op    <= bus.cmd_op;
            err_q <= 1'b0;
            k     <= 2'd0;
            i     <= 3'd0;
            tcnt  <= 8'd0;
            state <= REQ;
          end
        end
        REQ: begin
          if (bus.halt_ack) begin
            state <= op ? LOAD_WAIT : DUMP_RD;
          end else if (tcnt == TMO_LAST) begin
            err_q <= 1'b1;
            state <= DONE;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        DUMP_RD: begin
          // Register file reads combinationally from the selects driven now.
          buf0  <= bus.rf_ra;
          buf1  <= bus.rf_rb;
          state <= DUMP_OUT0;
        end
        DUMP_OUT0: begin
          if (bus.dm_ready) state <= DUMP_OUT1;
        end
        DUMP_OUT1: begin
          if (bus.dm_ready) begin
            if (k == 2'd3) begin
              state <= DONE;
            end else begin
              k     <= k + 2'd1;
              state <= DUMP_RD;
            end
          end
        end
        LOAD_WAIT: begin
          if (bus.ld_valid) begin
            wbuf  <= bus.ld_data;
            state <= LOAD_WR;
          end
        end
        LOAD_WR: begin
          if (i == 3'd7) begin
            state <= DONE;
          end else begin
            i     <= i + 3'd1;
            state <= LOAD_WAIT;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.halt_req  = (state != IDLE) && (state != DONE);
  assign bus.done      = (state == DONE);
  assign bus.err       = err_q;

  assign bus.rf_sr1 = (state == DUMP_RD) ? {k, 1'b0} : 3'd0;
  assign bus.rf_sr2 = (state == DUMP_RD) ? {k, 1'b1} : 3'd0;

  assign bus.dm_valid = (state == DUMP_OUT0) || (state == DUMP_OUT1);
  assign bus.dm_data  = (state == DUMP_OUT0) ? buf0 :
                        (state == DUMP_OUT1) ? buf1 : 16'd0;
  assign bus.dm_idx   = (state == DUMP_OUT0) ? {k, 1'b0} :
                        (state == DUMP_OUT1) ? {k, 1'b1} : 3'd0;

  assign bus.ld_ready = (state == LOAD_WAIT);

  // A write must not land if halt_ack drops in the write cycle itself.
  assign bus.rf_we   = (state == LOAD_WR) && bus.halt_ack;
  assign bus.rf_dr   = (state == LOAD_WR) ? i : 3'd0;
  assign bus.rf_buss = (state == LOAD_WR) ? wbuf : 16'd0;

endmodule
